puf_eval_ctrl: RTL and testbench

- Initiator side of the PUF evaluation interface: accepts a challenge/PDL-config request from the host handler, drives the PUF datapath's challenge, config, reset and trigger inputs, waits for arbiter settling, then samples raw and XOR responses and returns them.
- Sits between the host-side handler and the PUF mapping/interconnect datapath; sole owner of PUF reset/trigger timing.

---
 rtl/puf_pkg.sv | 30 +++
 rtl/puf_vote_accum.sv | 42 ++++
 rtl/puf_eval_ctrl.sv | 165 ++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared states, default widths and timing for the PUF evaluation controller
package puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ARM,
      FIRE,
      CAPTURE,
      DONE
   } state_t;

   localparam int DEF_CHALLENGE_WIDTH  = 64;
   localparam int DEF_PDL_CONFIG_WIDTH = 128;
   localparam int DEF_RESPONSE_WIDTH   = 6;
   localparam int DEF_CLEAR_CYCLES     = 4;
   localparam int DEF_SETUP_CYCLES     = 8;
   localparam int DEF_SETTLE_CYCLES    = 16;
   localparam int DEF_NUM_REPS         = 5;

   // Ones counters hold up to 15 repetitions.
   localparam int VOTE_CNT_W = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/puf_vote_accum.sv
// rtl/puf_vote_accum.sv - per-bit ones counters and majority decision over repeated PUF evaluations
module puf_vote_accum
   import puf_pkg::*;
#(
   parameter int RESPONSE_WIDTH = DEF_RESPONSE_WIDTH,
   parameter int NUM_REPS       = DEF_NUM_REPS
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      sample,
   input  logic [RESPONSE_WIDTH-1:0] raw,
   input  logic                      xor_bit,
   output logic [RESPONSE_WIDTH-1:0] maj_raw,
   output logic                      maj_xor
);

   localparam logic [VOTE_CNT_W-1:0] HALF = VOTE_CNT_W'(NUM_REPS / 2);

   logic [VOTE_CNT_W-1:0] raw_cnt [RESPONSE_WIDTH];
   logic [VOTE_CNT_W-1:0] xor_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RESPONSE_WIDTH; i++) raw_cnt[i] <= '0;
         xor_cnt <= '0;
      end else if (clear) begin
         for (int i = 0; i < RESPONSE_WIDTH; i++) raw_cnt[i] <= '0;
         xor_cnt <= '0;
      end else if (sample) begin
         for (int i = 0; i < RESPONSE_WIDTH; i++) raw_cnt[i] <= raw_cnt[i] + VOTE_CNT_W'(raw[i]);
         xor_cnt <= xor_cnt + VOTE_CNT_W'(xor_bit);
      end
   end

   always_comb begin
      maj_raw = '0;
      for (int i = 0; i < RESPONSE_WIDTH; i++) maj_raw[i] = (raw_cnt[i] > HALF);
      maj_xor = (xor_cnt > HALF);
   end

endmodule

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - PUF evaluation initiator: sequences clear/arm/fire/capture and returns the response
// Optional majority vote over NUM_REPS evaluations: define PUF_MAJORITY_VOTE_EN.
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int CHALLENGE_WIDTH  = DEF_CHALLENGE_WIDTH,
   parameter int PDL_CONFIG_WIDTH = DEF_PDL_CONFIG_WIDTH,
   parameter int RESPONSE_WIDTH   = DEF_RESPONSE_WIDTH,
   parameter int CLEAR_CYCLES     = DEF_CLEAR_CYCLES,
   parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
   parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
   parameter int NUM_REPS         = DEF_NUM_REPS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [CHALLENGE_WIDTH-1:0]  req_challenge,
   input  logic [PDL_CONFIG_WIDTH-1:0] req_pdl_config,
   output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
   output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
   output logic                        puf_reset,
   output logic                        puf_trigger,
   input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
   input  logic                        puf_xor_response,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [RESPONSE_WIDTH-1:0]   rsp_raw,
   output logic                        rsp_xor,
   output logic                        busy
);

   localparam int CW    = $clog2(max3(CLEAR_CYCLES, SETUP_CYCLES, SETTLE_CYCLES) + 1);
   localparam int REP_W = $clog2(NUM_REPS + 1);
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int EVALS = NUM_REPS;
`else
   localparam int EVALS = 1;
`endif

   localparam logic [CW-1:0] CLEAR_LOAD  = CW'(CLEAR_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LOAD  = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic              accept;
   logic              rep_last;

   assign accept   = (state == IDLE) && req_valid && req_ready;
   assign rep_last = (rep_cnt == REP_W'(EVALS - 1));

`ifdef PUF_MAJORITY_VOTE_EN
   logic [RESPONSE_WIDTH-1:0] maj_raw;
   logic                      maj_xor;

   puf_vote_accum #(
      .RESPONSE_WIDTH (RESPONSE_WIDTH),
      .NUM_REPS       (NUM_REPS)
   ) u_vote (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .sample  (state == CAPTURE),
      .raw     (puf_raw_response),
      .xor_bit (puf_xor_response),
      .maj_raw (maj_raw),
      .maj_xor (maj_xor)
   );
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         rep_cnt        <= '0;
         req_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_raw        <= '0;
         rsp_xor        <= 1'b0;
         puf_reset      <= 1'b1;
         puf_trigger    <= 1'b0;
         puf_challenge  <= '0;
         puf_pdl_config <= '0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  puf_challenge  <= req_challenge;
                  puf_pdl_config <= req_pdl_config;
                  req_ready      <= 1'b0;
                  busy           <= 1'b1;
                  rep_cnt        <= '0;
                  cnt            <= CLEAR_LOAD;
                  state          <= CLEAR;
               end
            end
            CLEAR: begin
               if (cnt == '0) begin
                  puf_reset <= 1'b0;
                  cnt       <= SETUP_LOAD;
                  state     <= ARM;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ARM: begin
               if (cnt == '0) begin
                  puf_trigger <= 1'b1;
                  cnt         <= SETTLE_LOAD;
                  state       <= FIRE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIRE: begin
               // Trigger drops a cycle before sampling; arbiters stay latched until puf_reset.
               if (cnt == '0) begin
                  puf_trigger <= 1'b0;
                  cnt         <= '0;
                  state       <= CAPTURE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CAPTURE: begin
               puf_reset <= 1'b1;
`ifndef PUF_MAJORITY_VOTE_EN
               rsp_raw   <= puf_raw_response;
               rsp_xor   <= puf_xor_response;
`endif
               if (rep_last) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
                  cnt     <= CLEAR_LOAD;
                  state   <= CLEAR;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; handshake can only follow it.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                  rsp_raw   <= maj_raw;
                  rsp_xor   <= maj_xor;
`endif
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - directed self-checking bench for puf_eval_ctrl
module tb_puf_eval_ctrl;

   localparam int CW_W = 64;
   localparam int PW_W = 128;
   localparam int RW_W = 6;
`ifdef PUF_MAJORITY_VOTE_EN
   localparam int LATENCY = 5 * (4 + 8 + 16 + 1) + 1;
`else
   localparam int LATENCY = 4 + 8 + 16 + 2;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [CW_W-1:0] req_challenge = '0;
   logic [PW_W-1:0] req_pdl_config = '0;
   logic [CW_W-1:0] puf_challenge;
   logic [PW_W-1:0] puf_pdl_config;
   logic            puf_reset;
   logic            puf_trigger;
   logic [RW_W-1:0] puf_raw_response;
   logic            puf_xor_response;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [RW_W-1:0] rsp_raw;
   logic            rsp_xor;
   logic            busy;

   // Model: mode 0 returns fixed values, mode 1 derives them from the applied challenge.
   int              model_mode = 0;
   logic [RW_W-1:0] model_raw = '0;
   logic            model_xor = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign puf_raw_response = (model_mode == 1) ? puf_challenge[RW_W-1:0] : model_raw;
   assign puf_xor_response = (model_mode == 1) ? ^puf_challenge : model_xor;

   puf_eval_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_challenge    (req_challenge),
      .req_pdl_config   (req_pdl_config),
      .puf_challenge    (puf_challenge),
      .puf_pdl_config   (puf_pdl_config),
      .puf_reset        (puf_reset),
      .puf_trigger      (puf_trigger),
      .puf_raw_response (puf_raw_response),
      .puf_xor_response (puf_xor_response),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_raw          (rsp_raw),
      .rsp_xor          (rsp_xor),
      .busy             (busy)
   );

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp += 9;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      if (rsp_raw !== 6'h00) begin n_err++; $display("FAIL reset_rsp_raw got %h want 00", rsp_raw); end
      if (rsp_xor !== 1'b0) begin n_err++; $display("FAIL reset_rsp_xor got %b want 0", rsp_xor); end
      if (puf_reset !== 1'b1) begin n_err++; $display("FAIL reset_puf_reset got %b want 1", puf_reset); end
      if (puf_trigger !== 1'b0) begin n_err++; $display("FAIL reset_puf_trigger got %b want 0", puf_trigger); end
      if (puf_challenge !== 64'h0) begin n_err++; $display("FAIL reset_puf_challenge got %h want 0", puf_challenge); end
      if (puf_pdl_config !== 128'h0) begin n_err++; $display("FAIL reset_puf_pdl_config got %h want 0", puf_pdl_config); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n, first_hi, rst_fall, trig_rise, chal_bad;
      logic prev_trig, in_first;
      model_mode = 0; model_raw = 6'b101101; model_xor = 1'b0;
      req_challenge = 64'hDEADBEEF_01234567;
      req_pdl_config = {PW_W{1'b1}};
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0; first_hi = 0; rst_fall = -1; trig_rise = -1; chal_bad = 0;
      prev_trig = 1'b0; in_first = 1'b1;
      while (!rsp_valid && n < 400) begin
         if (puf_reset === 1'b0 && rst_fall < 0) rst_fall = n;
         if (puf_trigger === 1'b1 && trig_rise < 0) trig_rise = n;
         if (puf_trigger === 1'b1 && in_first) first_hi++;
         if (prev_trig === 1'b1 && puf_trigger === 1'b0) in_first = 1'b0;
         if (puf_challenge !== 64'hDEADBEEF_01234567) chal_bad++;
         prev_trig = puf_trigger;
         @(negedge clk);
         n++;
      end
      n_cmp += 9;
      if (n !== LATENCY) begin n_err++; $display("FAIL basic_latency got %0d want %0d", n, LATENCY); end
      if (rsp_raw !== 6'b101101) begin n_err++; $display("FAIL basic_rsp_raw got %b want 101101", rsp_raw); end
      if (rsp_xor !== 1'b0) begin n_err++; $display("FAIL basic_rsp_xor got %b want 0", rsp_xor); end
      if (first_hi !== 16) begin n_err++; $display("FAIL basic_trigger_width got %0d want 16", first_hi); end
      if (trig_rise - rst_fall < 8 || rst_fall < 0) begin
         n_err++; $display("FAIL ordering_reset_to_trigger got %0d want >=8", trig_rise - rst_fall);
      end
      if (chal_bad !== 0) begin n_err++; $display("FAIL ordering_challenge_stable got %0d changes want 0", chal_bad); end
      if (puf_pdl_config !== {PW_W{1'b1}}) begin n_err++; $display("FAIL basic_pdl_config got %h want all ones", puf_pdl_config); end
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL basic_req_ready_done got %b want 0", req_ready); end
      if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done got %b want 1", busy); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp += 3;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_rsp_valid_after got %b want 0", rsp_valid); end
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL basic_req_ready_after got %b want 1", req_ready); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      int n, bad;
      model_mode = 0; model_raw = 6'b010011; model_xor = 1'b1;
      req_challenge = 64'h0000_1111_2222_3333;
      req_pdl_config = 128'h5;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_challenge = 64'hFFFF_0000_FFFF_0000;
      n = 0;
      while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
      rsp_ready = 1'b0;
      model_raw = 6'b111000; model_xor = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_raw !== 6'b010011 || rsp_xor !== 1'b1 ||
             req_ready !== 1'b0 || puf_challenge !== 64'h0000_1111_2222_3333) bad++;
      end
      n_cmp += 1;
      if (bad !== 0) begin n_err++; $display("FAIL backpressure_hold got %0d bad cycles want 0", bad); end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_cmp += 2;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL backpressure_release got %b want 0", rsp_valid); end
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL backpressure_req_ready got %b want 1", req_ready); end
   endtask

   task automatic test_back_to_back();
      int n, results, rises, rst_hi, min_gap;
      logic prev_trig, after_first;
      logic [RW_W-1:0] got_raw [2];
      logic            got_xor [2];
      logic [CW_W-1:0] rise_chal [2];
      model_mode = 1;
      req_challenge = 64'h33;
      req_pdl_config = 128'h0;
      req_valid = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_challenge = 64'h2A;
      n = 0; results = 0; rises = 0; rst_hi = 0; min_gap = 999;
      prev_trig = 1'b0; after_first = 1'b0;
      while (results < 2 && n < 800) begin
         if (puf_challenge === 64'h2A) req_valid = 1'b0;
         if (puf_trigger === 1'b1 && prev_trig === 1'b0) begin
            if (rises < 2) rise_chal[rises] = puf_challenge;
            if (after_first && rst_hi < min_gap) min_gap = rst_hi;
            rises++;
         end
         if (prev_trig === 1'b1 && puf_trigger === 1'b0) begin after_first = 1'b1; rst_hi = 0; end
         if (puf_reset === 1'b1 && puf_trigger === 1'b0) rst_hi++;
         if (rsp_valid === 1'b1) begin
            got_raw[results] = rsp_raw;
            got_xor[results] = rsp_xor;
            results++;
         end
         prev_trig = puf_trigger;
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp += 1;
      if (results !== 2) begin n_err++; $display("FAIL b2b_results got %0d want 2", results); end
      else begin
         n_cmp += 4;
         if (got_raw[0] !== 6'h33) begin n_err++; $display("FAIL b2b_raw0 got %h want 33", got_raw[0]); end
         if (got_xor[0] !== 1'b0) begin n_err++; $display("FAIL b2b_xor0 got %b want 0", got_xor[0]); end
         if (got_raw[1] !== 6'h2A) begin n_err++; $display("FAIL b2b_raw1 got %h want 2a", got_raw[1]); end
         if (got_xor[1] !== 1'b1) begin n_err++; $display("FAIL b2b_xor1 got %b want 1", got_xor[1]); end
      end
      n_cmp += 2;
      if (rises < 2 || rise_chal[0] !== 64'h33 || rise_chal[1] !== 64'h2A) begin
         n_err++; $display("FAIL b2b_order got rises %0d want challenges 33 then 2a", rises);
      end
      if (min_gap < 4 || min_gap == 999) begin n_err++; $display("FAIL b2b_reset_gap got %0d want >=4", min_gap); end
      n_cmp += 1;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle got req_ready %b want 1", req_ready); end
   endtask

   task automatic test_reset_mid_fire();
      int seen;
      model_mode = 0; model_raw = 6'h15; model_xor = 1'b1;
      req_challenge = 64'hCAFE;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp += 1;
      if (puf_trigger !== 1'b1) begin n_err++; $display("FAIL midfire_trigger_before got %b want 1", puf_trigger); end
      reset = 1'b0;
      #1;
      n_cmp += 4;
      if (puf_trigger !== 1'b0) begin n_err++; $display("FAIL midfire_trigger got %b want 0", puf_trigger); end
      if (puf_reset !== 1'b1) begin n_err++; $display("FAIL midfire_puf_reset got %b want 1", puf_reset); end
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL midfire_rsp_valid got %b want 0", rsp_valid); end
      if (puf_challenge !== 64'h0) begin n_err++; $display("FAIL midfire_challenge got %h want 0", puf_challenge); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) seen++;
      end
      n_cmp += 1;
      if (seen !== 0) begin n_err++; $display("FAIL midfire_after_release got %0d bad cycles want 0", seen); end
   endtask

`ifdef PUF_MAJORITY_VOTE_EN
   task automatic test_majority_vote();
      int n, rises;
      logic prev_trig;
      logic [RW_W-1:0] tbl_raw [5];
      logic            tbl_xor [5];
      tbl_raw[0] = 6'h3F; tbl_raw[1] = 6'h3F; tbl_raw[2] = 6'h00; tbl_raw[3] = 6'h3F; tbl_raw[4] = 6'h00;
      tbl_xor[0] = 1'b1; tbl_xor[1] = 1'b0; tbl_xor[2] = 1'b0; tbl_xor[3] = 1'b1; tbl_xor[4] = 1'b0;
      model_mode = 0; model_raw = 6'h00; model_xor = 1'b0;
      req_challenge = 64'h77;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0; rises = 0; prev_trig = 1'b0;
      while (!rsp_valid && n < 400) begin
         if (puf_trigger === 1'b1 && prev_trig === 1'b0) begin
            if (rises < 5) begin model_raw = tbl_raw[rises]; model_xor = tbl_xor[rises]; end
            rises++;
         end
         prev_trig = puf_trigger;
         @(negedge clk);
         n++;
      end
      n_cmp += 4;
      if (n !== LATENCY) begin n_err++; $display("FAIL vote_latency got %0d want %0d", n, LATENCY); end
      if (rises !== 5) begin n_err++; $display("FAIL vote_triggers got %0d want 5", rises); end
      if (rsp_raw !== 6'h3F) begin n_err++; $display("FAIL vote_raw got %h want 3f", rsp_raw); end
      if (rsp_xor !== 1'b0) begin n_err++; $display("FAIL vote_xor got %b want 0", rsp_xor); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_fire();
`ifdef PUF_MAJORITY_VOTE_EN
      test_majority_vote();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
